// File: rtl/score_compositor.sv
// score_compositor: round-based BCD score keeper with v_sync-gated display
// value, saturating decimal addition and best-score tracking.
module score_compositor #(
  parameter bit          SYNC_TO_VSYNC = 1'b1,
  parameter logic [11:0] SAT_BCD       = 12'h999
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_game_start,
  input  logic        i_is_end,
  input  logic        i_hit,
  input  logic [3:0]  i_points,
  output logic [11:0] o_score_value,
  output logic [11:0] o_high_score,
  output logic        o_new_high,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    LATCH = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t      r_state;
  logic [11:0] r_work;
  logic [11:0] r_score;
  logic [11:0] r_high;
  logic        r_new_high;
  logic        r_vs_prev;

  logic [3:0]  w_pts;
  logic [3:0]  w_carry;
  logic [11:0] w_sum;
  logic        w_sat;
  logic [11:0] w_next_work;
  logic        w_vs_rise;

  // Points above a single decimal digit are clamped so the ones-digit add
  // never needs more than one carry.
  assign w_pts     = (i_points > 4'd9) ? 4'd9 : i_points;
  assign w_vs_rise = i_v_sync & ~r_vs_prev;

  // Ripple-carry BCD adder: points enter the ones digit, carries ripple up.
  assign w_carry[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bcd
      logic [3:0] w_addend;
      logic [4:0] w_dsum;
      logic [4:0] w_adj;
      assign w_addend         = (gi == 0) ? w_pts : 4'd0;
      assign w_dsum           = {1'b0, r_work[gi*4 +: 4]} + {1'b0, w_addend}
                              + {4'd0, w_carry[gi]};
      assign w_adj            = w_dsum - 5'd10;
      assign w_carry[gi+1]    = (w_dsum > 5'd9);
      assign w_sum[gi*4 +: 4] = w_carry[gi+1] ? w_adj[3:0] : w_dsum[3:0];
    end
  endgenerate

  // A carry out of the hundreds digit or a sum above the ceiling pins the
  // score at the ceiling; packed BCD compares correctly as unsigned binary.
  assign w_sat       = w_carry[3] | (w_sum > SAT_BCD);
  assign w_next_work = w_sat ? SAT_BCD : w_sum;

  // Round FSM with working score, display value and high-score registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_work     <= 12'h000;
      r_score    <= 12'h000;
      r_high     <= 12'h000;
      r_new_high <= 1'b0;
      r_vs_prev  <= 1'b0;
    end else begin
      r_vs_prev <= i_v_sync;
      case (r_state)
        IDLE: begin
          if (i_game_start) begin
            r_state <= PLAY;
            r_work  <= 12'h000;
            r_score <= 12'h000;
          end
        end
        PLAY: begin
          if (i_hit) begin
            r_work <= w_next_work;
          end
          if (!SYNC_TO_VSYNC || w_vs_rise) begin
            r_score <= r_work;
          end
          if (i_is_end) begin
            r_state <= LATCH;
          end
        end
        LATCH: begin
          // Final score is shown unconditionally and judged against the best.
          r_score <= r_work;
          if (r_work > r_high) begin
            r_high     <= r_work;
            r_new_high <= 1'b1;
          end else begin
            r_new_high <= 1'b0;
          end
          r_state <= SHOW;
        end
        SHOW: begin
          if (i_game_start) begin
            r_state    <= PLAY;
            r_work     <= 12'h000;
            r_score    <= 12'h000;
            r_new_high <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_score_value = r_score;
  assign o_high_score  = r_high;
  assign o_new_high    = r_new_high;
  assign o_state       = r_state;

endmodule
